sad_search_ctrl: RTL

SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

---
 rtl/sad_search_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: sequences row reads for a block-matching search over
// CANDS candidate positions, accumulates the per-row SAD returned by the
// datapath two cycles later, and reports the candidate with the smallest
// block SAD. Ties keep the lower candidate index.
module sad_search_ctrl #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int ROWS   = 4,
  parameter int CANDS  = 16,
  localparam int SADW  = WIDTH + $clog2(INPUTS),
  localparam int ACCW  = SADW + $clog2(ROWS),
  localparam int CW    = $clog2(CANDS),
  localparam int RW    = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            issue_valid,
  output logic [CW-1:0]   issue_cand,
  output logic [RW-1:0]   issue_row,
  input  logic [SADW-1:0] sad_in,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] best_sad,
  output logic [CW-1:0]   best_idx
);

  // Combined {candidate, row} issue index; row is the low (inner) field.
  localparam int IW = CW + RW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   drain_q, drain_d;

  // Registered outputs; issue_cand/issue_row double as the issue counter.
  logic          issue_valid_q, issue_valid_d;
  logic [CW-1:0] issue_cand_q, issue_cand_d;
  logic [RW-1:0] issue_row_q, issue_row_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [IW-1:0] idx_next;

  // Two-stage tag pipeline matching the datapath latency.
  logic          v1_valid_q, v1_valid_d;
  logic          v1_first_q, v1_first_d;
  logic          v1_last_q, v1_last_d;
  logic [CW-1:0] v1_cand_q, v1_cand_d;
  logic          v2_valid_q, v2_valid_d;
  logic          v2_first_q, v2_first_d;
  logic          v2_last_q, v2_last_d;
  logic [CW-1:0] v2_cand_q, v2_cand_d;
  logic          flush;

  // Accumulation and minimum tracking.
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] acc_sum;
  logic [ACCW-1:0] min_q, min_d;
  logic [CW-1:0]   min_idx_q, min_idx_d;
  logic [ACCW-1:0] best_sad_q, best_sad_d;
  logic [CW-1:0]   best_idx_q, best_idx_d;

  // Next-state logic and the next values of the registered control outputs.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    idx_next = {issue_cand_q, issue_row_q};
    case (state_q)
      IDLE: begin
        drain_d = 1'b0;
        if (start) begin
          state_d  = ISSUE;
          idx_next = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (&{issue_cand_q, issue_row_q}) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          idx_next = {issue_cand_q, issue_row_q} + IW'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (drain_q) begin
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    issue_valid_d = (state_d == ISSUE);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    if (state_d == ISSUE) begin
      issue_cand_d = idx_next[IW-1:RW];
      issue_row_d  = idx_next[RW-1:0];
    end else begin
      issue_cand_d = '0;
      issue_row_d  = '0;
    end
  end

  // Delay the issue tags by two cycles; an abort empties the pipeline.
  always_comb begin
    flush = abort && ((state_q == ISSUE) || (state_q == DRAIN));
    if (flush) begin
      v1_valid_d = 1'b0;
      v1_first_d = 1'b0;
      v1_last_d  = 1'b0;
      v1_cand_d  = '0;
      v2_valid_d = 1'b0;
      v2_first_d = 1'b0;
      v2_last_d  = 1'b0;
      v2_cand_d  = '0;
    end else begin
      v1_valid_d = issue_valid_q;
      v1_first_d = issue_valid_q && (issue_row_q == RW'(0));
      v1_last_d  = issue_valid_q && (issue_row_q == RW'(ROWS - 1));
      v1_cand_d  = issue_cand_q;
      v2_valid_d = v1_valid_q;
      v2_first_d = v1_first_q;
      v2_last_d  = v1_last_q;
      v2_cand_d  = v1_cand_q;
    end
  end

  // Accumulate row SADs, keep the running minimum, publish it on completion.
  always_comb begin
    acc_d      = acc_q;
    min_d      = min_q;
    min_idx_d  = min_idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    acc_sum    = (v2_first_q ? {ACCW{1'b0}} : acc_q) + ACCW'(sad_in);
    if (v2_valid_q) begin
      acc_d = acc_sum;
      // Candidate 0 seeds the minimum, so leftovers from a prior search never matter.
      if (v2_last_q && ((v2_cand_q == CW'(0)) || (acc_sum < min_q))) begin
        min_d     = acc_sum;
        min_idx_d = v2_cand_q;
      end else begin
        min_d     = min_q;
        min_idx_d = min_idx_q;
      end
    end else begin
      acc_d = acc_q;
    end
    // The final row is sampled in the same cycle as this transition, so use min_d.
    if ((state_q == DRAIN) && (state_d == DONE)) begin
      best_sad_d = min_d;
      best_idx_d = min_idx_d;
    end else begin
      best_sad_d = best_sad_q;
      best_idx_d = best_idx_q;
    end
  end

  // State, outputs and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      drain_q       <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_cand_q  <= '0;
      issue_row_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      v1_valid_q    <= 1'b0;
      v1_first_q    <= 1'b0;
      v1_last_q     <= 1'b0;
      v1_cand_q     <= '0;
      v2_valid_q    <= 1'b0;
      v2_first_q    <= 1'b0;
      v2_last_q     <= 1'b0;
      v2_cand_q     <= '0;
      acc_q         <= '0;
      min_q         <= '0;
      min_idx_q     <= '0;
      best_sad_q    <= '0;
      best_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      issue_valid_q <= issue_valid_d;
      issue_cand_q  <= issue_cand_d;
      issue_row_q   <= issue_row_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      v1_valid_q    <= v1_valid_d;
      v1_first_q    <= v1_first_d;
      v1_last_q     <= v1_last_d;
      v1_cand_q     <= v1_cand_d;
      v2_valid_q    <= v2_valid_d;
      v2_first_q    <= v2_first_d;
      v2_last_q     <= v2_last_d;
      v2_cand_q     <= v2_cand_d;
      acc_q         <= acc_d;
      min_q         <= min_d;
      min_idx_q     <= min_idx_d;
      best_sad_q    <= best_sad_d;
      best_idx_q    <= best_idx_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_cand  = issue_cand_q;
  assign issue_row   = issue_row_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_sad    = best_sad_q;
  assign best_idx    = best_idx_q;

endmodule
